// File: rtl/lcd_char_streamer.sv
// rtl/lcd_char_streamer.sv - character FIFO feeding a 2x16 HD44780-style LCD over an Avalon-MM write port
//
// Purpose: accepts a stream of ASCII bytes (0x0A = newline), buffers them in a
// FIFO, and drives instruction/data writes to an LCD slave while tracking the cursor.
// Optional feature macro: LCD_CHAR_FILTER_EN (non-printable bytes written as '?').
//
// Ports:
//   clk, reset            clock, synchronous active-low reset
//   char_data/valid/ready character input handshake
//   clear_req             one-cycle pulse: flush FIFO and clear the display
//   busy                  FIFO non-empty, clear pending, or FSM not idle
//   cursor_pos            {row, column} of the next character write
//   address/chipselect/write/writedata/waitrequest  Avalon-MM write master

module lcd_char_streamer #(
    parameter int FIFO_DEPTH = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] char_data,
    input  logic       char_valid,
    output logic       char_ready,
    input  logic       clear_req,
    output logic       busy,
    output logic [4:0] cursor_pos,
    output logic       address,
    output logic       chipselect,
    output logic       write,
    output logic [7:0] writedata,
    input  logic       waitrequest
);

    localparam int AW = $clog2(FIFO_DEPTH);

    typedef enum logic [2:0] {
        INIT_CLR, INIT_HOME, IDLE, POP, SET_ADDR, WR_CHAR, CLR, HOME
    } state_t;

    state_t          r_state, w_next;
    logic [7:0]      r_mem [FIFO_DEPTH];
    logic [AW-1:0]   r_wr_ptr, r_rd_ptr;
    logic [AW:0]     r_count;
    logic            r_clr_pend, r_gap, r_row;
    logic [3:0]      r_col;
    logic [7:0]      r_char;

    logic            w_full, w_empty, w_push, w_pop, w_xfer, w_done;
    logic [7:0]      w_head, w_head_filt, w_data;

    assign w_full  = (r_count == (AW+1)'(FIFO_DEPTH));
    assign w_empty = (r_count == '0);
    assign w_push  = char_valid && char_ready;
    assign w_pop   = (r_state == POP) && !w_empty;
    assign w_head  = r_mem[r_rd_ptr];

`ifdef LCD_CHAR_FILTER_EN
    assign w_head_filt = (w_head != 8'h0A && (w_head < 8'h20 || w_head > 8'h7E)) ? 8'h3F : w_head;
`else
    assign w_head_filt = w_head;
`endif

    // Bus-owning states; write drops for one cycle after each completion (r_gap)
    assign w_xfer = (r_state == INIT_CLR) || (r_state == INIT_HOME) || (r_state == SET_ADDR) ||
                    (r_state == WR_CHAR)  || (r_state == CLR)       || (r_state == HOME);
    assign w_done = write && !waitrequest;

    assign char_ready = reset && !w_full;
    assign busy       = !w_empty || r_clr_pend || (r_state != IDLE);
    assign cursor_pos = {r_row, r_col};
    assign write      = reset && w_xfer && !r_gap;
    assign chipselect = write;
    assign address    = reset && (r_state == WR_CHAR);
    assign writedata  = reset ? w_data : 8'h00;

    always_comb begin
        w_data = 8'h00;
        case (r_state)
            INIT_CLR, CLR:   w_data = 8'h01;
            INIT_HOME, HOME: w_data = 8'h80;
            SET_ADDR:        w_data = r_row ? 8'hC0 : 8'h80;
            WR_CHAR:         w_data = r_char;
            default:         w_data = 8'h00;
        endcase
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            INIT_CLR:  if (w_done) w_next = INIT_HOME;
            INIT_HOME: if (w_done) w_next = IDLE;
            // A push this cycle bypasses the empty check so the write lands two cycles later;
            // a clear arriving in the same cycle flushes that push, so it blocks the bypass.
            IDLE: begin
                if (r_clr_pend)
                    w_next = CLR;
                else if (!clear_req && (!w_empty || w_push))
                    w_next = POP;
            end
            POP: begin
                if (w_empty)
                    w_next = IDLE;
                else if (w_head == 8'h0A)
                    w_next = SET_ADDR;
                else
                    w_next = WR_CHAR;
            end
            SET_ADDR: if (w_done) w_next = IDLE;
            // A wrap normally re-addresses the new row, but a pending clear makes it pointless
            WR_CHAR: begin
                if (w_done)
                    w_next = (r_col == 4'hF && !r_clr_pend && !clear_req) ? SET_ADDR : IDLE;
            end
            CLR:  if (w_done) w_next = HOME;
            HOME: if (w_done) w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (w_push)
            r_mem[r_wr_ptr] <= char_data;
    end

    always_ff @(posedge clk) begin
        if (!reset || clear_req) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state    <= INIT_CLR;
            r_gap      <= 1'b0;
            r_clr_pend <= 1'b0;
            r_row      <= 1'b0;
            r_col      <= 4'h0;
            r_char     <= 8'h00;
        end else begin
            r_state <= w_next;
            r_gap   <= w_done;

            if (w_next == CLR && r_state != CLR)
                r_clr_pend <= 1'b0;
            else if (clear_req)
                r_clr_pend <= 1'b1;

            if (w_pop) begin
                r_char <= w_head_filt;
                if (w_head == 8'h0A) begin
                    r_row <= ~r_row;
                    r_col <= 4'h0;
                end
            end

            if (r_state == WR_CHAR && w_done) begin
                if (r_col == 4'hF) begin
                    r_row <= ~r_row;
                    r_col <= 4'h0;
                end else begin
                    r_col <= r_col + 1'b1;
                end
            end

            if (r_state == HOME && w_done) begin
                r_row <= 1'b0;
                r_col <= 4'h0;
            end
        end
    end

endmodule

// File: tb/tb_lcd_char_streamer.sv
// tb/tb_lcd_char_streamer.sv - self-checking bench for lcd_char_streamer against a cursor/write-list model

module tb_lcd_char_streamer;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [7:0] char_data = 8'h00;
    logic       char_valid = 1'b0;
    logic       clear_req = 1'b0;
    logic       char_ready, busy, address, chipselect, write;
    logic [4:0] cursor_pos;
    logic [7:0] writedata;
    logic       wr_manual = 1'b0, wr_rnd = 1'b0, rand_mode = 1'b0;
    logic       waitrequest;

    assign waitrequest = rand_mode ? wr_rnd : wr_manual;

    lcd_char_streamer #(.FIFO_DEPTH(16)) dut (
        .clk(clk), .reset(reset), .char_data(char_data), .char_valid(char_valid),
        .char_ready(char_ready), .clear_req(clear_req), .busy(busy), .cursor_pos(cursor_pos),
        .address(address), .chipselect(chipselect), .write(write), .writedata(writedata),
        .waitrequest(waitrequest)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;
    logic [8:0] got_q[$];
    logic [8:0] exp_q[$];
    logic       m_row = 1'b0;
    logic [3:0] m_col = 4'h0;
    int         last_len = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] filt(input logic [7:0] c);
        logic [7:0] r;
        r = c;
`ifdef LCD_CHAR_FILTER_EN
        if (c != 8'h0A && (c < 8'h20 || c > 8'h7E)) r = 8'h3F;
`endif
        return r;
    endfunction

    // Expected bus writes and cursor for one character, straight from the display rules
    task automatic model_char(input logic [7:0] c);
        if (c == 8'h0A) begin
            m_row = ~m_row;
            m_col = 4'h0;
            exp_q.push_back({1'b0, m_row ? 8'hC0 : 8'h80});
        end else begin
            exp_q.push_back({1'b1, filt(c)});
            if (m_col == 4'hF) begin
                m_col = 4'h0;
                m_row = ~m_row;
                exp_q.push_back({1'b0, m_row ? 8'hC0 : 8'h80});
            end else begin
                m_col = m_col + 4'h1;
            end
        end
    endtask

    task automatic model_clear();
        exp_q.push_back(9'h001);
        exp_q.push_back(9'h080);
        m_row = 1'b0;
        m_col = 4'h0;
    endtask

    task automatic compare_sb(input string tag);
        check_eq({tag, "_nwr"}, got_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size(); i++)
            if (i < got_q.size())
                check_eq({tag, "_wr"}, {23'd0, got_q[i]}, {23'd0, exp_q[i]});
        check_eq({tag, "_cur"}, cursor_pos, {m_row, m_col});
        got_q.delete();
        exp_q.delete();
    endtask

    task automatic wait_idle(input string tag);
        int n;
        n = 0;
        @(posedge clk); #1;
        forever begin
            @(negedge clk);
            if (!busy || n > 3000) break;
            n++;
        end
        check_eq({tag, "_idle"}, busy, 0);
        @(posedge clk); #1;
    endtask

    task automatic wait_write(input string tag);
        int n;
        n = 0;
        forever begin
            @(negedge clk);
            if (write || n > 200) break;
            n++;
        end
        check_eq({tag, "_wstart"}, write, 1);
        @(posedge clk); #1;
    endtask

    task automatic push_char(input logic [7:0] c);
        logic ok;
        int   n;
        n = 0;
        char_valid = 1'b1;
        char_data  = c;
        forever begin
            @(negedge clk);
            ok = char_ready;
            @(posedge clk); #1;
            if (ok) break;
            n++;
            if (n > 5000) begin
                check_eq("push_timeout", 0, 1);
                break;
            end
        end
        char_valid = 1'b0;
        model_char(c);
    endtask

    task automatic do_clear(input string tag);
        clear_req = 1'b1;
        @(posedge clk); #1;
        clear_req = 1'b0;
        model_clear();
        wait_idle(tag);
        compare_sb(tag);
    endtask

    // Bus monitor: collects completed writes and checks hold/gap/strobe rules
    initial begin
        logic p_done, p_hold, p_addr;
        logic [7:0] p_data;
        int len;
        p_done = 0; p_hold = 0; p_addr = 0; p_data = 0; len = 0;
        forever begin
            @(negedge clk);
            if (!reset) begin
                p_done = 0;
                p_hold = 0;
                len = 0;
            end else begin
                if (p_done) check_eq("gap", write, 0);
                if (p_hold) check_eq("hold", {write, address, writedata}, {1'b1, p_addr, p_data});
                check_eq("cs_eq_wr", chipselect, write);
                p_done = write && !waitrequest;
                p_hold = write && waitrequest;
                p_addr = address;
                p_data = writedata;
                if (write) begin
                    len++;
                    if (!waitrequest) begin
                        got_q.push_back({address, writedata});
                        last_len = len;
                        len = 0;
                    end
                end
            end
        end
    end

    initial begin
        forever begin
            @(posedge clk); #1;
            wr_rnd = ($urandom_range(0, 2) == 0);
        end
    end

    initial begin
        int   acc;
        logic ok;
        logic [7:0] rc;

        repeat (3) @(posedge clk);
        #1;
        @(negedge clk);
        check_eq("rst_out", {address, chipselect, write, writedata}, 0);
        check_eq("rst_rdy", char_ready, 0);
        check_eq("rst_cur", cursor_pos, 0);
        @(posedge clk); #1;
        reset = 1'b1;
        @(negedge clk);
        check_eq("rel_first", {busy, write, address, writedata}, {1'b1, 1'b1, 1'b0, 8'h01});
        exp_q.push_back(9'h001);
        exp_q.push_back(9'h080);
        wait_idle("init");
        compare_sb("init");

        wr_manual  = 1'b1;
        char_valid = 1'b1;
        char_data  = 8'h41;
        @(negedge clk);
        check_eq("lat_rdy", char_ready, 1);
        @(posedge clk); #1;
        char_valid = 1'b0;
        model_char(8'h41);
        @(negedge clk);
        check_eq("lat_n1", write, 0);
        @(posedge clk); #1;
        @(negedge clk);
        check_eq("lat_n2", {write, address, writedata}, {1'b1, 1'b1, 8'h41});
        @(posedge clk); #1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        wr_manual = 1'b0;
        wait_idle("lat");
        check_eq("lat_len", last_len, 4);
        check_eq("lat_cur1", cursor_pos, 5'h01);
        compare_sb("lat");

        do_clear("clr1");
        for (int c = 8'h30; c <= 8'h40; c++) push_char(c[7:0]);
        wait_idle("wrap");
        check_eq("wrap_cur11", cursor_pos, 5'h11);
        compare_sb("wrap");

        do_clear("clr2");
        push_char(8'h58);
        push_char(8'h0A);
        push_char(8'h59);
        wait_idle("nl");
        check_eq("nl_cur11", cursor_pos, 5'h11);
        compare_sb("nl");

        rand_mode = 1'b1;
        for (int i = 0; i < 80; i++) begin
            case ($urandom_range(0, 9))
                0:       rc = 8'h0A;
                1:       rc = 8'($urandom_range(0, 255));
                default: rc = 8'($urandom_range(8'h20, 8'h7E));
            endcase
            push_char(rc);
            repeat ($urandom_range(0, 2)) begin
                @(posedge clk); #1;
            end
        end
        wait_idle("rnd");
        rand_mode = 1'b0;
        compare_sb("rnd");

        do_clear("clr3");
        wr_manual = 1'b1;
        push_char(8'h61);
        wait_write("fill");
        acc = 0;
        char_valid = 1'b1;
        for (int i = 0; i < 40; i++) begin
            char_data = 8'($urandom_range(8'h20, 8'h7E));
            @(negedge clk);
            ok = char_ready;
            @(posedge clk); #1;
            if (!ok) break;
            acc++;
        end
        char_valid = 1'b0;
        check_eq("fill_cnt", acc, 16);
        @(negedge clk);
        check_eq("fill_rdy", char_ready, 0);
        @(posedge clk); #1;
        clear_req = 1'b1;
        @(posedge clk); #1;
        clear_req = 1'b0;
        @(negedge clk);
        check_eq("flush_rdy", char_ready, 1);
        check_eq("flush_wr_held", write, 1);
        @(posedge clk); #1;
        @(posedge clk); #1;
        wr_manual = 1'b0;
        model_clear();
        wait_idle("fill");
        compare_sb("fill");

        push_char(8'h07);
        wait_idle("filt");
        compare_sb("filt");

        wr_manual = 1'b1;
        push_char(8'h5A);
        wait_write("mrst");
        reset = 1'b0;
        @(negedge clk);
        check_eq("mrst_wr", {write, chipselect}, 0);
        @(posedge clk); #1;
        @(negedge clk);
        check_eq("mrst_state", {char_ready, cursor_pos, address, writedata}, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
